// File: rtl/led_pattern_gen.sv
// led_pattern_gen
// Pushbutton-driven LED pattern engine. It has four display modes, eight
// step speeds and debounced key control. Everything runs from CLOCK_50.
//
// Ports:
//   CLOCK_50  in   sole clock, rising edge
//   RESET_N   in   asynchronous active-low reset
//   KEY_N[2:0] in  active-low keys, asynchronous:
//                  [0] next mode, [1] faster, [2] slower
//   LED       out  LED_COUNT registered LED drive, active-high
//   MODE      out  0 BLINK, 1 CHASE, 2 BINARY, 3 BREATHE
//   SPEED     out  speed level, 0 slowest .. 7 fastest
//
// Build option: define LED_PWM_EN to include the BREATHE mode and its PWM
// logic. Without it the mode sequence is BLINK -> CHASE -> BINARY -> BLINK.

// Per-key synchroniser, debouncer and press detector.
//   gclk/grst_n clock and async reset, tick base tick strobe,
//   key_n raw key level, press 1-cycle pulse on a debounced 1->0 transition.
module led_key_debounce #(
  parameter int DEBOUNCE_TICKS = 10
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic tick,
  input  logic key_n,
  output logic press
);
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);

  logic [1:0]    sync;
  logic          stable;
  logic [DW-1:0] cnt;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      sync   <= 2'b11;
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync  <= {sync[0], key_n};
      press <= 1'b0;
      if (sync[1] == stable) begin
        cnt <= '0;
      end else if (tick) begin
        // The DEBOUNCE_TICKS-th consecutive differing tick accepts the level.
        if (cnt == DW'(DEBOUNCE_TICKS - 1)) begin
          stable <= sync[1];
          cnt    <= '0;
          press  <= ~sync[1];
        end else begin
          cnt <= cnt + DW'(1);
        end
      end
    end
  end
endmodule

module led_pattern_gen #(
  parameter int TICK_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 10,
  parameter int LED_COUNT      = 10
) (
  input  logic                 CLOCK_50,
  input  logic                 RESET_N,
  input  logic [2:0]           KEY_N,
  output logic [LED_COUNT-1:0] LED,
  output logic [1:0]           MODE,
  output logic [2:0]           SPEED
);
  localparam int TW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    M_BLINK   = 2'd0,
    M_CHASE   = 2'd1,
    M_BINARY  = 2'd2,
    M_BREATHE = 2'd3
  } mode_e;

  // Base tick
  logic [TW-1:0] tick_cnt;
  logic          tick;
  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  // Keys
  logic [2:0] press;
  for (genvar g = 0; g < 3; g++) begin : g_key
    led_key_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_key (
      .gclk  (CLOCK_50),
      .grst_n(RESET_N),
      .tick  (tick),
      .key_n (KEY_N[g]),
      .press (press[g])
    );
  end

  // Speed: opposite presses in the same cycle cancel.
  logic [2:0] speed_q, speed_d;
  logic       speed_chg;
  always_comb begin
    speed_d = speed_q;
    if (press[1] && !press[2] && speed_q != 3'd7)
      speed_d = speed_q + 3'd1;
    else if (press[2] && !press[1] && speed_q != 3'd0)
      speed_d = speed_q - 3'd1;
  end
  assign speed_chg = (speed_d != speed_q);

  // Step period is 16 << (7-SPEED) ticks; its terminal count is 2047 >> SPEED.
  logic [10:0] step_cnt, step_last;
  logic        step, step_go;
  assign step_last = 11'h7FF >> speed_q;
  assign step      = tick && (step_cnt == step_last);
  // Any press wins over a coincident step, so the step is dropped.
  assign step_go   = step && !(|press);

  // Mode / pattern state
  mode_e                mode_q, mode_d;
  logic [LED_COUNT-1:0] led_q, led_d;

`ifdef LED_PWM_EN
  logic [3:0] pwm_cnt, duty_q, duty_d;
  logic       rising_q, rising_d;
  logic       pwm_on;
  assign pwm_on = (pwm_cnt < duty_q);
`endif

  always_comb begin
    mode_d = mode_q;
    led_d  = led_q;
`ifdef LED_PWM_EN
    duty_d   = duty_q;
    rising_d = rising_q;
`endif
    if (press[0]) begin
      case (mode_q)
        M_BLINK:  mode_d = M_CHASE;
        M_CHASE:  mode_d = M_BINARY;
`ifdef LED_PWM_EN
        M_BINARY: mode_d = M_BREATHE;
`else
        M_BINARY: mode_d = M_BLINK;
`endif
        default:  mode_d = M_BLINK;
      endcase
      // Entry pattern of the new mode.
      led_d = (mode_d == M_CHASE) ? LED_COUNT'(1) : '0;
`ifdef LED_PWM_EN
      duty_d   = 4'd0;
      rising_d = 1'b1;
`endif
    end else begin
      if (step_go) begin
        case (mode_q)
          M_BLINK:  led_d = ~led_q;
          M_CHASE:  led_d = {led_q[LED_COUNT-2:0], led_q[LED_COUNT-1]};
          M_BINARY: led_d = led_q + LED_COUNT'(1);
`ifdef LED_PWM_EN
          M_BREATHE: begin
            // Triangle 0..15..0: the end points are visited once per sweep.
            if (rising_q) begin
              if (duty_q == 4'd15) begin
                duty_d   = 4'd14;
                rising_d = 1'b0;
              end else begin
                duty_d = duty_q + 4'd1;
              end
            end else begin
              if (duty_q == 4'd0) begin
                duty_d   = 4'd1;
                rising_d = 1'b1;
              end else begin
                duty_d = duty_q - 4'd1;
              end
            end
          end
`endif
          default: led_d = led_q;
        endcase
      end
`ifdef LED_PWM_EN
      if (mode_q == M_BREATHE)
        led_d = {LED_COUNT{pwm_on}};
`endif
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      tick_cnt <= '0;
      step_cnt <= '0;
      speed_q  <= 3'd4;
      mode_q   <= M_BLINK;
      led_q    <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      speed_q  <= speed_d;
      mode_q   <= mode_d;
      led_q    <= led_d;
      // A new mode or a new period restarts the step from zero.
      if (press[0] || speed_chg)
        step_cnt <= '0;
      else if (tick)
        step_cnt <= step ? '0 : step_cnt + 11'd1;
    end
  end

`ifdef LED_PWM_EN
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      pwm_cnt  <= '0;
      duty_q   <= '0;
      rising_q <= 1'b1;
    end else begin
      pwm_cnt  <= pwm_cnt + 4'd1;
      duty_q   <= duty_d;
      rising_q <= rising_d;
    end
  end
`endif

  assign LED   = led_q;
  assign MODE  = mode_q;
  assign SPEED = speed_q;
endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised LED pattern generator driven by the board pushbuttons. It replaces a fixed single-rate blinker with a configurable engine that offers multiple display modes, selectable speed and debounced key control. It sits in the FPGA fabric next to the HPS system, between the KEY inputs and the LEDR outputs, and requires no software involvement.

## Interface
- TICK_DIV, 50000: CLOCK_50 cycles per base tick (1 ms at 50 MHz); must be ≥2.
- DEBOUNCE_TICKS, 10: number of consecutive stable ticks needed to accept a key level.
- LED_COUNT, 10: number of LED outputs; must be ≥2.
- CLOCK_50  in  1  sole clock; all logic is rising-edge.
- RESET_N  in  1  asynchronous, active-low reset, synchronously deasserted by the instantiating top.
- KEY_N  in  3  active-low pushbuttons, asynchronous to CLOCK_50: [0] next mode, [1] faster, [2] slower.
- LED  out  LED_COUNT  LED drive, active-high, registered.
- MODE  out  2  current mode: 0 BLINK, 1 CHASE, 2 BINARY, 3 BREATHE.
- SPEED  out  3  current speed level, 0 (slowest) to 7.

## Operation
- Reset values: LED=0, MODE=0, SPEED=4. All counters are cleared. The debounced key state is "released" (1).
- Tick counter runs 0..TICK_DIV-1 and emits a 1-cycle `tick` pulse on wrap.
- Key path per bit:
  - 2-FF synchroniser, then a debounce counter that advances on `tick` while the synced value differs from the stable value.
  - The counter clears whenever the two values match.
  - At DEBOUNCE_TICKS the stable value updates.
  - A stable 1→0 transition generates a 1-cycle press pulse. Release generates nothing.
- Speed:
  - A faster press increments SPEED, saturating at 7.
  - A slower press decrements SPEED, saturating at 0.
  - Faster and slower pressed in the same cycle cancel; SPEED is unchanged.
  - Any SPEED change clears the step counter.
- Step period: P = 16 << (7-SPEED) ticks, i.e. 2048 ticks at SPEED 0, 128 at SPEED 4, 16 at SPEED 7.
  - The step counter advances on `tick`.
  - When it reaches P-1 it emits a 1-cycle `step` pulse and returns to 0.
- Mode press: MODE advances 0→1→2→3→0. The step counter clears and the new mode's entry pattern is loaded in the same cycle.
- Modes:
  - BLINK: entry LED=0. Each step inverts all bits.
  - CHASE: entry LED=1 (bit 0). Each step rotates left; the MSB wraps to bit 0.
  - BINARY: entry LED=0. Each step adds 1 modulo 2^LED_COUNT.
  - BREATHE: see Configuration.
- Simultaneous mode and speed presses are both applied in the same cycle.
- RESET_N low at any time, including mid-step or mid-debounce, immediately forces all reset values. There is no partial state.

## Timing
- Key to press pulse: 2 cycles of synchroniser latency, plus DEBOUNCE_TICKS ticks of stability, plus at most 1 tick of alignment.
- Press pulse to MODE/SPEED/LED entry pattern: 1 cycle, since all outputs are registered.
- `step` pulse to LED update: 1 cycle.
- First BLINK toggle after reset release: LED goes all-ones at cycle 128·TICK_DIV+1, within ±1 cycle.
- A press arriving in the same cycle as `step` takes priority: the entry pattern loads and the step is discarded.

## Configuration
- LED_PWM_EN defined: BREATHE mode is present.
  - A 4-bit duty level moves as a triangle 0,1,…,15,14,…,0,1,… advancing one value per `step`. Entry is duty 0, rising.
  - A free-running 4-bit PWM counter increments every cycle.
  - All LED bits equal (pwm_cnt < duty). Duty 0 gives LED=0; duty 15 gives 15/16 on-time.
- LED_PWM_EN undefined: no PWM logic is built.
  - The mode sequence is 0→1→2→0.
  - MODE never reads 3.

## Test plan
- Reset with TICK_DIV=4, DEBOUNCE_TICKS=2 → LED=0, MODE=0, SPEED=4. LED becomes all-ones about 512 cycles after reset release, and returns to 0 after 512 more.
- KEY_N[0] low for 1 tick, then high → MODE stays 0. KEY_N[0] low for 4 ticks → MODE=1 and LED=0000000001. After one step LED=0000000010. After 10 steps LED=0000000001 again.
- 4 presses of KEY_N[1] → SPEED=7 (saturated) with a 16-tick step period. Then 8 presses of KEY_N[2] → SPEED=0 with a 2048-tick period. KEY_N[1] and KEY_N[2] pressed together → SPEED unchanged.
- LED_COUNT=4 in BINARY mode, 16 steps → LED counts 0..15 and wraps to 0.
- With LED_PWM_EN, in BREATHE mode at step 8 (duty 8) → LED high for 8 of every 16 cycles. Without LED_PWM_EN, a mode press from MODE=2 → MODE=0 and LED=0.
- RESET_N pulsed low mid-CHASE and mid-debounce → LED=0, MODE=0, SPEED=4 asynchronously. No press pulse fires after release.
